// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall sequencer
package pipe_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_stall_sequencer_if.sv
// rtl/pipeline_stall_sequencer_if.sv - request inputs, stage controls and counters of the stall sequencer
interface pipeline_stall_sequencer_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             HazardStall;
  logic             Redirect;
  logic             ICacheStall;
  logic             DCacheStall;
  logic             PcWrite;
  logic             IfIdWrite;
  logic             IfIdFlush;
  logic             IdExFlush;
  logic             ExMemWrite;
  logic             MemWbWrite;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic             MemTimeout;

  modport master (
    output HazardStall, Redirect, ICacheStall, DCacheStall,
    input  PcWrite, IfIdWrite, IfIdFlush, IdExFlush, ExMemWrite, MemWbWrite,
    input  StallCount, FlushCount, MemTimeout
  );

  modport slave (
    input  HazardStall, Redirect, ICacheStall, DCacheStall,
    output PcWrite, IfIdWrite, IfIdFlush, IdExFlush, ExMemWrite, MemWbWrite,
    output StallCount, FlushCount, MemTimeout
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// rtl/pipeline_stall_sequencer.sv - arbitrates memory/hazard stalls and redirects into stage enables and flushes
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_stall_sequencer_if.slave     bus
);

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  logic              flush_pending;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout;
  logic              mem_stall;

  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write;
  logic [CNT_W-1:0] stall_count, flush_count;

  assign mem_stall = bus.ICacheStall | bus.DCacheStall;

  // A MEM_WAIT release cycle falls through to the plain RUN rules.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (state == FLUSH) begin
      ifid_flush = 1'b1;
    end else if (bus.HazardStall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (bus.Redirect) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      flush_pending <= 1'b0;
      wait_cnt      <= '0;
      mem_timeout   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state         <= MEM_WAIT;
            flush_pending <= bus.Redirect;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (bus.Redirect) flush_pending <= 1'b1;
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= '0;
            state    <= flush_pending ? FLUSH : RUN;
          end
        end
        FLUSH: begin
          // A freeze here defers the flush; flush_pending stays set.
          if (mem_stall) begin
            state <= MEM_WAIT;
          end else begin
            state         <= RUN;
            flush_pending <= 1'b0;
          end
        end
        default: begin
          state         <= RUN;
          flush_pending <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write | idex_flush),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifid_flush),
    .count (flush_count)
  );

  assign bus.PcWrite    = pc_write;
  assign bus.IfIdWrite  = ifid_write;
  assign bus.IfIdFlush  = ifid_flush;
  assign bus.IdExFlush  = idex_flush;
  assign bus.ExMemWrite = exmem_write;
  assign bus.MemWbWrite = memwb_write;
  assign bus.StallCount = stall_count;
  assign bus.FlushCount = flush_count;
  assign bus.MemTimeout = mem_timeout;

endmodule

// File: doc/pipeline_stall_sequencer.md
Name: pipeline_stall_sequencer

Overview:
- Consumes the stall and redirect requests of the 5-stage MIPS pipeline and drives the per-stage write enables and flushes.
- Request sources: hazard detection Stall, branch/jr resolution in ID, and I-cache/D-cache busy.
- Keeps a small FSM so that a redirect arriving during a memory freeze is not lost.
- Counts stall and flush cycles for performance reporting, with a memory-wait watchdog.
- Sits between the hazard detection unit, the caches, and the pipeline registers/PC.

Parameters:
- CNT_W, 32, width of the saturating performance counters
- TIMEOUT, 1023, memory-freeze cycles (in MEM_WAIT) after which MemTimeout is raised

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- HazardStall  input  1  load-use / branch-operand stall from hazard detection
- Redirect  input  1  branch taken or jr/j resolved in ID this cycle
- ICacheStall  input  1  instruction fetch not ready
- DCacheStall  input  1  data access not ready
- PcWrite  output  1  PC register update enable
- IfIdWrite  output  1  IF/ID register enable
- IfIdFlush  output  1  zero IF/ID on next edge
- IdExFlush  output  1  insert bubble into ID/EX on next edge
- ExMemWrite  output  1  EX/MEM enable
- MemWbWrite  output  1  MEM/WB enable
- StallCount  output  CNT_W  cycles with any stall output active
- FlushCount  output  CNT_W  IfIdFlush pulses issued
- MemTimeout  output  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous, active-low.
- Reset values:
  - State = RUN.
  - FlushPending = 0, StallCount = 0, FlushCount = 0, MemTimeout = 0, wait counter = 0.
  - All enables read 1 and all flushes read 0 while in RUN with no requests.
- Enables and flushes are combinational from inputs and state, with zero-cycle latency. Counters and flags are registered.
- MemStall = ICacheStall | DCacheStall. Priority, highest first: MemStall, then HazardStall, then Redirect.
- State RUN:
  - MemStall:
    - All enables (PcWrite, IfIdWrite, ExMemWrite, MemWbWrite) = 0; no flush.
    - If Redirect is also asserted, set FlushPending = 1.
    - Next state MEM_WAIT.
  - HazardStall (no MemStall):
    - PcWrite = 0, IfIdWrite = 0, IdExFlush = 1; ExMemWrite = MemWbWrite = 1.
    - Redirect is ignored this cycle; the hazard unit holds the branch in ID.
  - Redirect only: PcWrite = 1, IfIdFlush = 1, all other enables 1.
  - Otherwise: all enables 1, all flushes 0.
- State MEM_WAIT:
  - All enables = 0 while MemStall is asserted.
  - A Redirect seen during the wait sets FlushPending.
  - The wait counter increments each cycle.
  - Wait counter reaching TIMEOUT sets MemTimeout. MemTimeout is cleared only by reset.
  - MemStall drop with FlushPending = 1: go to FLUSH. This release cycle applies RUN rules to the current inputs (including the HazardStall and Redirect rules).
  - MemStall drop with FlushPending = 0: go to RUN, same release-cycle rule.
  - The wait counter clears on release.
- State FLUSH (exactly one cycle):
  - IfIdFlush = 1, PcWrite = 1, other enables 1. FlushPending cleared.
  - MemStall in this cycle overrides: enables 0, flush deferred, FlushPending held, back to MEM_WAIT.
  - Otherwise the next state is RUN.
- Simultaneous HazardStall and Redirect: the stall wins. The Redirect takes effect when HazardStall drops, because Redirect remains asserted.
- Counters:
  - StallCount increments in any cycle with PcWrite = 0 or IdExFlush = 1.
  - FlushCount increments on each IfIdFlush cycle.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-freeze or mid-FLUSH: return immediately to the reset values. Any pending flush is discarded.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2
  - the CNT_W default
- One natural sub-module: sat_counter (parameterised width, increment enable, saturate), instantiated for StallCount and FlushCount.

Test Plan:
- Reset: hold rst_n = 0 with random inputs, then release → PcWrite = IfIdWrite = ExMemWrite = MemWbWrite = 1, flushes 0, StallCount = FlushCount = 0, MemTimeout = 0.
- Load-use: HazardStall = 1 for 1 cycle → PcWrite = 0, IfIdWrite = 0, IdExFlush = 1 that cycle; StallCount = 1; next cycle all enables 1.
- Redirect alone: Redirect = 1 for 1 cycle → IfIdFlush = 1, PcWrite = 1; FlushCount = 1; StallCount unchanged.
- Redirect under freeze: ICacheStall = 1 for 4 cycles with Redirect = 1 in cycle 2 only → enables 0 for 4 cycles; release cycle has no flush; the following cycle has IfIdFlush = 1 (FLUSH); StallCount = 4; FlushCount = 1.
- Watchdog: DCacheStall held 1100 cycles with TIMEOUT = 1023 → MemTimeout rises after 1023 MEM_WAIT cycles and stays 1 after release. With CNT_W = 4, StallCount saturates at 15.
- Priority: HazardStall = Redirect = DCacheStall = 1 → full freeze, no flush, FlushPending set. After DCacheStall drops with HazardStall still 1: release cycle has IdExFlush = 1; the next cycle (FLUSH) has IfIdFlush = 1.
